// File: rtl/repair_task_scheduler.sv
// Purpose : sequences repair missions (find fault, pick block, drop block) and
//           is the sole requester of the path-planner CPU; fault messages are queued.
// Ports   : unit_valid/unit_id feed the queue; su/fault_found/fault_node/pick_done/
//           drop_done/cpu_busy are planner/bot events; cpu_en/ep issue path requests;
//           state/cur_unit/queue_*/drop_ovf/retry_cnt/msg_*/mission_done report status.
// Latency : cpu_en one cycle after leaving IDLE when cpu_busy=0; all outputs registered.
module repair_task_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 3125000,
  parameter logic [4:0]  EP_EU   = 5'd29,
  parameter logic [4:0]  EP_CU   = 5'd8,
  parameter logic [4:0]  EP_RU   = 5'd19,
  parameter logic [4:0]  EP_SU0  = 5'd22,
  parameter logic [4:0]  EP_SU1  = 5'd10,
  parameter logic [4:0]  EP_SU2  = 5'd23,
  parameter logic [4:0]  EP_SU3  = 5'd11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       unit_valid,
  input  logic [1:0] unit_id,
  input  logic [1:0] su,
  input  logic       fault_found,
  input  logic [4:0] fault_node,
  input  logic       pick_done,
  input  logic       drop_done,
  input  logic       cpu_busy,
  output logic       cpu_en,
  output logic [4:0] ep,
  output logic [2:0] state,
  output logic [1:0] cur_unit,
  output logic [2:0] queue_count,
  output logic       queue_full,
  output logic       drop_ovf,
  output logic [3:0] retry_cnt,
  output logic       msg_fim,
  output logic       msg_bpm,
  output logic [2:0] msg_bdm,
  output logic       mission_done
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_REQ_UNIT   = 3'd1;
  localparam logic [2:0] S_WAIT_FAULT = 3'd2;
  localparam logic [2:0] S_REQ_PICK   = 3'd3;
  localparam logic [2:0] S_WAIT_PICK  = 3'd4;
  localparam logic [2:0] S_REQ_DROP   = 3'd5;
  localparam logic [2:0] S_WAIT_DROP  = 3'd6;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    CNT_FULL = 3'(DEPTH);

  // ---------------------------------------------------------------------------
  // Fault-message queue
  // ---------------------------------------------------------------------------
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          drop_ovf_q, drop_ovf_d;
  logic          full;
  logic          empty;
  logic          msg_ok;
  logic          push;
  logic          pop;

  // Fullness is judged on the registered count, so a same-cycle pop never
  // makes room for the incoming message.
  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == 3'd0);
  assign msg_ok = unit_valid && (unit_id != 2'd3);
  assign push   = msg_ok && !full;

  // ---------------------------------------------------------------------------
  // FSM and mission registers
  // ---------------------------------------------------------------------------
  logic [2:0]    state_q, state_d;
  logic [1:0]    cur_unit_q, cur_unit_d;
  logic [1:0]    su_q, su_d;
  logic [4:0]    node_q, node_d;
  logic [4:0]    ep_q, ep_d;
  logic          cpu_en_q, cpu_en_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    retry_q, retry_d;
  logic          fim_q, fim_d;
  logic          bpm_q, bpm_d;
  logic [2:0]    bdm_q, bdm_d;
  logic          done_seen_q, done_seen_d;
  logic          tmo;
  logic          in_wait;
  logic [4:0]    unit_ep;
  logic [4:0]    su_ep;
  logic [3:0]    retry_inc;

  assign pop     = (state_q == S_IDLE) && !empty;
  assign tmo     = (timer_q == TMO_LAST);
  assign in_wait = (state_q == S_WAIT_FAULT) || (state_q == S_WAIT_PICK) ||
                   (state_q == S_WAIT_DROP);
  assign retry_inc = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;

  always_comb begin
    unit_ep = EP_RU;
    case (cur_unit_q)
      2'd0:    unit_ep = EP_EU;
      2'd1:    unit_ep = EP_CU;
      default: unit_ep = EP_RU;
    endcase
  end

  always_comb begin
    su_ep = EP_SU0;
    case (su_q)
      2'd0:    su_ep = EP_SU0;
      2'd1:    su_ep = EP_SU1;
      2'd2:    su_ep = EP_SU2;
      default: su_ep = EP_SU3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_unit_d  = cur_unit_q;
    su_d        = su_q;
    node_d      = node_q;
    ep_d        = ep_q;
    cpu_en_d    = 1'b0;
    retry_d     = retry_q;
    fim_d       = 1'b0;
    bpm_d       = 1'b0;
    bdm_d       = 3'd0;
    done_seen_d = done_seen_q;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          cur_unit_d = mem_q[rd_ptr_q];
          state_d    = S_REQ_UNIT;
        end
      end
      S_REQ_UNIT: begin
        if (!cpu_busy) begin
          cpu_en_d = 1'b1;
          ep_d     = unit_ep;
          state_d  = S_WAIT_FAULT;
        end
      end
      S_WAIT_FAULT: begin
        // Event takes priority over a coincident timeout.
        if (fault_found) begin
          node_d  = fault_node;
          su_d    = su;
          fim_d   = 1'b1;
          state_d = S_REQ_PICK;
        end else if (tmo) begin
          retry_d = retry_inc;
          state_d = S_REQ_UNIT;
        end
      end
      S_REQ_PICK: begin
        // su was captured on the way in, so pick retries reuse the same unit.
        if (!cpu_busy) begin
          cpu_en_d = 1'b1;
          ep_d     = su_ep;
          state_d  = S_WAIT_PICK;
        end
      end
      S_WAIT_PICK: begin
        if (pick_done) begin
          bpm_d   = 1'b1;
          state_d = S_REQ_DROP;
        end else if (tmo) begin
          retry_d = retry_inc;
          state_d = S_REQ_PICK;
        end
      end
      S_REQ_DROP: begin
        if (!cpu_busy) begin
          cpu_en_d = 1'b1;
          ep_d     = node_q;
          state_d  = S_WAIT_DROP;
        end
      end
      S_WAIT_DROP: begin
        if (drop_done) begin
          bdm_d       = {1'b0, su_q} + 3'd1;
          done_seen_d = 1'b1;
          state_d     = S_IDLE;
        end else if (tmo) begin
          retry_d = retry_inc;
          state_d = S_REQ_DROP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer runs only while parked in a WAIT state and restarts on any transition.
  always_comb begin
    timer_d = '0;
    if (in_wait && (state_d == state_q)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_ovf_d = drop_ovf_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
    if (msg_ok && full) begin
      drop_ovf_d = 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= unit_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 3'd0;
      drop_ovf_q  <= 1'b0;
      state_q     <= S_IDLE;
      cur_unit_q  <= 2'd0;
      su_q        <= 2'd0;
      node_q      <= 5'd0;
      ep_q        <= 5'd0;
      cpu_en_q    <= 1'b0;
      timer_q     <= '0;
      retry_q     <= 4'd0;
      fim_q       <= 1'b0;
      bpm_q       <= 1'b0;
      bdm_q       <= 3'd0;
      done_seen_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_ovf_q  <= drop_ovf_d;
      state_q     <= state_d;
      cur_unit_q  <= cur_unit_d;
      su_q        <= su_d;
      node_q      <= node_d;
      ep_q        <= ep_d;
      cpu_en_q    <= cpu_en_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      fim_q       <= fim_d;
      bpm_q       <= bpm_d;
      bdm_q       <= bdm_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign cpu_en       = cpu_en_q;
  assign ep           = ep_q;
  assign state        = state_q;
  assign cur_unit     = cur_unit_q;
  assign queue_count  = count_q;
  assign queue_full   = full;
  assign drop_ovf     = drop_ovf_q;
  assign retry_cnt    = retry_q;
  assign msg_fim      = fim_q;
  assign msg_bpm      = bpm_q;
  assign msg_bdm      = bdm_q;
  // A push makes the queue non-empty, which drops this on the following cycle.
  assign mission_done = (state_q == S_IDLE) && empty && done_seen_q;

endmodule

// File: tb/tb_repair_task_scheduler.sv
module tb_repair_task_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       unit_valid;
  logic [1:0] unit_id;
  logic [1:0] su;
  logic       fault_found;
  logic [4:0] fault_node;
  logic       pick_done;
  logic       drop_done;
  logic       cpu_busy;
  logic       cpu_en;
  logic [4:0] ep;
  logic [2:0] state;
  logic [1:0] cur_unit;
  logic [2:0] queue_count;
  logic       queue_full;
  logic       drop_ovf;
  logic [3:0] retry_cnt;
  logic       msg_fim;
  logic       msg_bpm;
  logic [2:0] msg_bdm;
  logic       mission_done;

  always #5 clk = ~clk;

  repair_task_scheduler #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .unit_valid(unit_valid), .unit_id(unit_id),
    .su(su), .fault_found(fault_found), .fault_node(fault_node),
    .pick_done(pick_done), .drop_done(drop_done), .cpu_busy(cpu_busy),
    .cpu_en(cpu_en), .ep(ep), .state(state), .cur_unit(cur_unit),
    .queue_count(queue_count), .queue_full(queue_full), .drop_ovf(drop_ovf),
    .retry_cnt(retry_cnt), .msg_fim(msg_fim), .msg_bpm(msg_bpm),
    .msg_bdm(msg_bdm), .mission_done(mission_done)
  );

  typedef struct {
    int uv; int id; int su; int ff; int fn; int pd; int dd; int busy;
  } in_t;
  typedef struct {
    int ce; int ep; int st; int cu; int qc; int qf; int ov; int rt;
    int fim; int bpm; int bdm; int dn;
  } out_t;
  typedef struct { in_t i; out_t o; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[14];

  function automatic vec_t mk(input int uv, id, s, ff, fn, pd, dd, bz,
                              input int ce, e, st, cu, qc, qf, ov, rt,
                              input int fim, bpm, bdm, dn);
    vec_t v;
    v.i = '{uv, id, s, ff, fn, pd, dd, bz};
    v.o = '{ce, e, st, cu, qc, qf, ov, rt, fim, bpm, bdm, dn};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    unit_valid  = 1'(v.uv);
    unit_id     = 2'(v.id);
    su          = 2'(v.su);
    fault_found = 1'(v.ff);
    fault_node  = 5'(v.fn);
    pick_done   = 1'(v.pd);
    drop_done   = 1'(v.dd);
    cpu_busy    = 1'(v.busy);
  endtask

  task automatic idle_in(input int s, input int bz);
    in_t v;
    v = '{0, 0, s, 0, 0, 0, 0, bz};
    drive(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".cpu_en"},       int'(cpu_en),       e.ce);
    chk({tag, ".ep"},           int'(ep),           e.ep);
    chk({tag, ".state"},        int'(state),        e.st);
    chk({tag, ".cur_unit"},     int'(cur_unit),     e.cu);
    chk({tag, ".queue_count"},  int'(queue_count),  e.qc);
    chk({tag, ".queue_full"},   int'(queue_full),   e.qf);
    chk({tag, ".drop_ovf"},     int'(drop_ovf),     e.ov);
    chk({tag, ".retry_cnt"},    int'(retry_cnt),    e.rt);
    chk({tag, ".msg_fim"},      int'(msg_fim),      e.fim);
    chk({tag, ".msg_bpm"},      int'(msg_bpm),      e.bpm);
    chk({tag, ".msg_bdm"},      int'(msg_bdm),      e.bdm);
    chk({tag, ".mission_done"}, int'(mission_done), e.dn);
  endtask

  initial begin
    out_t zero;
    zero = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    //            uv id su ff fn pd dd bz   ce ep st cu qc qf ov rt fim bpm bdm dn
    tbl[0]  = mk(1, 1, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 2, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 2, 0, 0, 0, 0, 0,   1, 8, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 2, 0, 0, 1, 1, 0,   0, 8, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 2, 1, 13, 0, 0, 0,  0, 8, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 2, 0, 0, 0, 0, 0,   1, 23, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 2, 0, 0, 1, 0, 0,   0, 23, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 2, 0, 0, 0, 0, 0,   1, 13, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 2, 0, 0, 0, 1, 0,   0, 13, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1);
    tbl[9]  = mk(0, 0, 2, 0, 0, 0, 0, 0,   0, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(1, 3, 2, 0, 0, 0, 0, 0,   0, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(1, 0, 2, 0, 0, 0, 0, 0,   0, 13, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 2, 0, 0, 0, 0, 0,   0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 2, 0, 0, 0, 0, 0,   1, 29, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    rst_n = 1'b0;
    idle_in(0, 0);
    tick();
    tick();
    check_out("reset", zero);
    rst_n = 1'b1;

    // CU mission end to end, then start an EU mission
    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].i);
      tick();
      check_out($sformatf("row%0d", r), tbl[r].o);
    end

    // Leg timeout: 16 waiting cycles, then back to REQ_UNIT and re-request
    idle_in(2, 0);
    for (int n = 1; n <= 15; n++) begin
      tick();
      chk($sformatf("tmo_wait%0d.state", n), int'(state), 2);
    end
    tick();
    chk("tmo.state", int'(state), 1);
    chk("tmo.retry_cnt", int'(retry_cnt), 1);
    chk("tmo.cpu_en", int'(cpu_en), 0);
    tick();
    chk("retry_req.cpu_en", int'(cpu_en), 1);
    chk("retry_req.ep", int'(ep), 29);
    chk("retry_req.state", int'(state), 2);

    // fault_found exactly on the timeout cycle wins
    for (int n = 1; n <= 15; n++) tick();
    fault_found = 1'b1;
    fault_node  = 5'd7;
    su          = 2'd1;
    tick();
    chk("ff_on_tmo.state", int'(state), 3);
    chk("ff_on_tmo.retry_cnt", int'(retry_cnt), 1);
    chk("ff_on_tmo.msg_fim", int'(msg_fim), 1);
    idle_in(3, 0);
    tick();
    chk("pick_req.cpu_en", int'(cpu_en), 1);
    chk("pick_req.ep", int'(ep), 10);
    chk("pick_req.state", int'(state), 4);
    pick_done = 1'b1;
    tick();
    chk("picked.state", int'(state), 5);
    chk("picked.msg_bpm", int'(msg_bpm), 1);

    // Planner busy for 10 cycles in REQ_DROP
    idle_in(3, 1);
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk($sformatf("busy%0d.cpu_en", n), int'(cpu_en), 0);
      chk($sformatf("busy%0d.state", n), int'(state), 5);
    end
    idle_in(3, 0);
    tick();
    chk("drop_req.cpu_en", int'(cpu_en), 1);
    chk("drop_req.ep", int'(ep), 7);
    chk("drop_req.state", int'(state), 6);
    drop_done = 1'b1;
    tick();
    chk("dropped.msg_bdm", int'(msg_bdm), 2);
    chk("dropped.state", int'(state), 0);
    chk("dropped.mission_done", int'(mission_done), 1);

    // Queue fill with the FSM parked in REQ_UNIT by cpu_busy
    idle_in(0, 1);
    unit_valid = 1'b1;
    unit_id = 2'd0; tick();
    chk("q1.count", int'(queue_count), 1);
    chk("q1.mission_done", int'(mission_done), 0);
    unit_id = 2'd1; tick();
    chk("q2.count", int'(queue_count), 1);
    chk("q2.state", int'(state), 1);
    chk("q2.cur_unit", int'(cur_unit), 0);
    unit_id = 2'd2; tick();
    chk("q3.count", int'(queue_count), 2);
    unit_id = 2'd0; tick();
    chk("q4.count", int'(queue_count), 3);
    chk("q4.full", int'(queue_full), 0);
    unit_id = 2'd1; tick();
    chk("q5.count", int'(queue_count), 4);
    chk("q5.full", int'(queue_full), 1);
    unit_id = 2'd3; tick();
    chk("q_inv.count", int'(queue_count), 4);
    chk("q_inv.drop_ovf", int'(drop_ovf), 0);
    unit_id = 2'd2; tick();
    chk("q_ovf.count", int'(queue_count), 4);
    chk("q_ovf.drop_ovf", int'(drop_ovf), 1);

    // Progress into WAIT_PICK, then reset mid-mission
    idle_in(0, 0);
    tick();
    chk("m3_req.cpu_en", int'(cpu_en), 1);
    chk("m3_req.ep", int'(ep), 29);
    fault_found = 1'b1;
    fault_node  = 5'd5;
    tick();
    chk("m3_ff.state", int'(state), 3);
    idle_in(0, 0);
    tick();
    chk("m3_pick.ep", int'(ep), 22);
    chk("m3_pick.state", int'(state), 4);
    rst_n = 1'b0;
    tick();
    check_out("midreset", zero);
    rst_n = 1'b1;
    tick();
    chk("post_reset.state", int'(state), 0);
    chk("post_reset.cpu_en", int'(cpu_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
